// File: rtl/gray_stream_decoder.sv
// gray_stream_decoder: decodes a Gray-coded count stream to binary and flags illegal steps
// Ports: clk/rst (async active-high), gray_in/gray_valid sample input, clr_err clears err_count;
//        bin_out/bin_valid decoded value, locked tracking status, step_err pulse, err_count saturating.
module gray_stream_decoder #(
  parameter int W          = 4,
  parameter int CNT_W      = 8,
  parameter int RELOCK_N   = 3,
  parameter int ALLOW_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     gray_in,
  input  logic             gray_valid,
  input  logic             clr_err,
  output logic [W-1:0]     bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             step_err,
  output logic [CNT_W-1:0] err_count
);
  localparam int RB = $clog2(RELOCK_N + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [W-1:0]     bin_new, diff, bin_out_q, bin_out_d;
  logic [RB-1:0]    bad_run_q, bad_run_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             bin_valid_q, bin_valid_d, step_err_q, step_err_d, good, last_bad;
  for (genvar i = 0; i < W; i++) begin : g_bin
    assign bin_new[i] = ^gray_in[W-1:i];
  end
  // bin_out_q always holds the last valid sample, so it doubles as the step reference
  assign diff     = bin_new - bin_out_q;
  assign good     = diff == W'(1) || (ALLOW_HOLD != 0 && diff == '0);
  assign last_bad = bad_run_q == RB'(RELOCK_N - 1);
  always_comb begin
    state_d     = state_q;
    bad_run_d   = bad_run_q;
    err_count_d = err_count_q;
    bin_out_d   = gray_valid ? bin_new : bin_out_q;
    bin_valid_d = gray_valid;
    step_err_d  = gray_valid && state_q == LOCKED && !good;
    if (gray_valid) begin
      if (state_q == IDLE) begin
        state_d   = LOCKED;
        bad_run_d = '0;
      end else if (good) begin
        bad_run_d = '0;
      end else begin
        err_count_d = &err_count_q ? err_count_q : err_count_q + 1'b1;
        state_d     = last_bad ? IDLE : LOCKED;
        bad_run_d   = last_bad ? '0 : bad_run_q + 1'b1;
      end
    end
    if (clr_err) err_count_d = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bad_run_q   <= '0;
      err_count_q <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bad_run_q   <= bad_run_d;
      err_count_q <= err_count_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      step_err_q  <= step_err_d;
    end
  end
  assign bin_out   = bin_out_q;
  assign bin_valid = bin_valid_q;
  assign locked    = state_q == LOCKED;
  assign step_err  = step_err_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_gray_stream_decoder.sv
// tb_gray_stream_decoder: scoreboard bench for three decoder configurations
module tb_gray_stream_decoder;
  typedef struct {
    logic [3:0] b;
    logic       se;
    logic       lk;
    logic [7:0] ec;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gv  [3];
  logic       clr [3];
  logic [3:0] gi  [3];
  logic [3:0] bo  [3];
  logic       bv  [3];
  logic       lk  [3];
  logic       se  [3];
  logic [7:0] ec  [3];
  logic [1:0] ec2;
  exp_t       sb  [3][$];
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  assign ec[2] = {6'b0, ec2};
  gray_stream_decoder #(.W(4), .CNT_W(8), .RELOCK_N(3), .ALLOW_HOLD(1)) u0 (
    .clk(clk), .rst(rst), .gray_in(gi[0]), .gray_valid(gv[0]), .clr_err(clr[0]),
    .bin_out(bo[0]), .bin_valid(bv[0]), .locked(lk[0]), .step_err(se[0]), .err_count(ec[0]));
  gray_stream_decoder #(.W(4), .CNT_W(8), .RELOCK_N(3), .ALLOW_HOLD(0)) u1 (
    .clk(clk), .rst(rst), .gray_in(gi[1]), .gray_valid(gv[1]), .clr_err(clr[1]),
    .bin_out(bo[1]), .bin_valid(bv[1]), .locked(lk[1]), .step_err(se[1]), .err_count(ec[1]));
  gray_stream_decoder #(.W(4), .CNT_W(2), .RELOCK_N(3), .ALLOW_HOLD(1)) u2 (
    .clk(clk), .rst(rst), .gray_in(gi[2]), .gray_valid(gv[2]), .clr_err(clr[2]),
    .bin_out(bo[2]), .bin_valid(bv[2]), .locked(lk[2]), .step_err(se[2]), .err_count(ec2));
  task automatic smp(input int k, input logic [3:0] g, input logic [3:0] b, input logic s,
                     input logic l, input logic [7:0] c, input logic cl);
    @(negedge clk);
    gv[k]  = 1'b1;
    gi[k]  = g;
    clr[k] = cl;
    sb[k].push_back(exp_t'{b, s, l, c});
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      gv[k]  = 1'b0;
      clr[k] = 1'b0;
    end
    repeat (n - 1) @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    exp_t       e;
    logic [3:0] v;
    for (int k = 0; k < 3; k++) begin
      gv[k]  = 1'b0;
      clr[k] = 1'b0;
      gi[k]  = '0;
    end
    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (bv[k]) begin
            checks++;
            if (sb[k].size() == 0) begin
              errors++;
              $display("FAIL dut%0d unexpected bin_valid: bin=%0d", k, bo[k]);
            end else begin
              e = sb[k].pop_front();
              if ({bo[k], se[k], lk[k], ec[k]} !== {e.b, e.se, e.lk, e.ec}) begin
                errors++;
                $display("FAIL dut%0d sample: got bin=%0d step_err=%0b locked=%0b err=%0d expected bin=%0d step_err=%0b locked=%0b err=%0d",
                         k, bo[k], se[k], lk[k], ec[k], e.b, e.se, e.lk, e.ec);
              end
            end
          end
        end
      end
    join_none
    #1;
    chk("reset bin_out", 32'(bo[0]), 0);
    chk("reset bin_valid", 32'(bv[0]), 0);
    chk("reset locked", 32'(lk[0]), 0);
    chk("reset step_err", 32'(se[0]), 0);
    chk("reset err_count", 32'(ec[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // full Gray count with wrap back to zero
    for (int b = 0; b < 17; b++) begin
      v = 4'(b);
      smp(0, v ^ (v >> 1), v, 1'b0, 1'b1, 8'd0, 1'b0);
    end
    idle(3);
    // single isolated sample after a mid-stream reset
    do_reset();
    smp(0, 4'b0110, 4'd4, 1'b0, 1'b1, 8'd0, 1'b0);
    idle(3);
    chk("hold bin_valid", 32'(bv[0]), 0);
    chk("hold bin_out", 32'(bo[0]), 4);
    chk("hold locked", 32'(lk[0]), 1);
    // one bad step, then recovery
    do_reset();
    smp(0, 4'b0011, 4'd2, 1'b0, 1'b1, 8'd0, 1'b0);
    smp(0, 4'b0110, 4'd4, 1'b1, 1'b1, 8'd1, 1'b0);
    smp(0, 4'b0111, 4'd5, 1'b0, 1'b1, 8'd1, 1'b0);
    idle(2);
    // three bad steps lose lock, next sample relocks
    do_reset();
    smp(0, 4'b0000, 4'd0, 1'b0, 1'b1, 8'd0, 1'b0);
    smp(0, 4'b0101, 4'd6, 1'b1, 1'b1, 8'd1, 1'b0);
    smp(0, 4'b1111, 4'd10, 1'b1, 1'b1, 8'd2, 1'b0);
    smp(0, 4'b0000, 4'd0, 1'b1, 1'b0, 8'd3, 1'b0);
    smp(0, 4'b0001, 4'd1, 1'b0, 1'b1, 8'd3, 1'b0);
    // legal hold across gaps
    smp(0, 4'b0011, 4'd2, 1'b0, 1'b1, 8'd3, 1'b0);
    idle(2);
    smp(0, 4'b0011, 4'd2, 1'b0, 1'b1, 8'd3, 1'b0);
    idle(2);
    // hold is an error when not allowed
    smp(1, 4'b0011, 4'd2, 1'b0, 1'b1, 8'd0, 1'b0);
    idle(2);
    smp(1, 4'b0011, 4'd2, 1'b1, 1'b1, 8'd1, 1'b0);
    idle(2);
    // 2-bit counter saturation and clear-beats-increment
    smp(2, 4'b0000, 4'd0, 1'b0, 1'b1, 8'd0, 1'b0);
    smp(2, 4'b0101, 4'd6, 1'b1, 1'b1, 8'd1, 1'b0);
    smp(2, 4'b0000, 4'd0, 1'b1, 1'b1, 8'd2, 1'b0);
    smp(2, 4'b0101, 4'd6, 1'b1, 1'b0, 8'd3, 1'b0);
    smp(2, 4'b0000, 4'd0, 1'b0, 1'b1, 8'd3, 1'b0);
    smp(2, 4'b0101, 4'd6, 1'b1, 1'b1, 8'd3, 1'b0);
    smp(2, 4'b0000, 4'd0, 1'b1, 1'b1, 8'd3, 1'b0);
    smp(2, 4'b0101, 4'd6, 1'b1, 1'b0, 8'd0, 1'b1);
    idle(2);
    // asynchronous reset between clock edges
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst u0 bin_out", 32'(bo[0]), 0);
    chk("async rst u0 locked", 32'(lk[0]), 0);
    chk("async rst u0 err_count", 32'(ec[0]), 0);
    chk("async rst u1 err_count", 32'(ec[1]), 0);
    chk("async rst u2 bin_out", 32'(bo[2]), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    for (int k = 0; k < 3; k++) chk($sformatf("dut%0d pending expectations", k), 32'(sb[k].size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
